// File: rtl/player_pkg.sv
// Shared definitions for the player motion block: state encoding and default physics constants.
package player_pkg;

    typedef enum logic [2:0] {
        ST_GROUNDED = 3'd0,
        ST_DUCK     = 3'd1,
        ST_RISING   = 3'd2,
        ST_FALLING  = 3'd3,
        ST_FASTDROP = 3'd4
    } motion_state_t;

    localparam int DEF_POS_W          = 8;
    localparam int DEF_VEL_W          = 8;
    localparam int DEF_JUMP_VEL       = 12;
    localparam int DEF_GRAVITY        = 2;
    localparam int DEF_HOLD_GRAVITY   = 1;
    localparam int DEF_FASTDROP_VEL   = 8;
    localparam int DEF_MAX_HOLD_TICKS = 4;

    function automatic logic is_airborne(input motion_state_t s);
        return s inside {ST_RISING, ST_FALLING, ST_FASTDROP};
    endfunction

endpackage

// File: rtl/sat_sub.sv
// Signed subtract a_i - b_i that clamps to the representable range instead of wrapping.
module sat_sub #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] diff_o
);

    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

    logic signed [W:0] wide;

    assign wide = $signed({a_i[W-1], a_i}) - $signed({b_i[W-1], b_i});

    // The top two bits disagree only when the true result left the W-bit range.
    always_comb begin
        if (wide[W] != wide[W-1]) begin
            diff_o = wide[W] ? MIN_V : MAX_V;
        end else begin
            diff_o = wide[W-1:0];
        end
    end

endmodule

// File: rtl/player_motion.sv
// Jump / duck / fast-drop motion controller: velocity updates on game_tick[0],
// position updates on game_tick[1], everything held while freeze is high.
module player_motion
    import player_pkg::*;
#(
    parameter int POS_W          = DEF_POS_W,
    parameter int VEL_W          = DEF_VEL_W,
    parameter int JUMP_VEL       = DEF_JUMP_VEL,
    parameter int GRAVITY        = DEF_GRAVITY,
    parameter int HOLD_GRAVITY   = DEF_HOLD_GRAVITY,
    parameter int FASTDROP_VEL   = DEF_FASTDROP_VEL,
    parameter int MAX_HOLD_TICKS = DEF_MAX_HOLD_TICKS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              game_tick,
    input  logic                    freeze,
    input  logic                    button_up,
    input  logic                    button_down,
    output logic [POS_W-1:0]        height,
    output logic signed [VEL_W-1:0] velocity,
    output logic                    airborne,
    output logic                    ducking,
    output logic                    jump_pulse,
    output logic                    landed_pulse
);

    localparam int SUM_W = POS_W + 2;
    localparam int CNT_W = $clog2(MAX_HOLD_TICKS + 1);

    localparam logic signed [VEL_W-1:0] JUMP_V   = VEL_W'(JUMP_VEL);
    localparam logic signed [VEL_W-1:0] GRAV_V   = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0] HOLD_V   = VEL_W'(HOLD_GRAVITY);
    localparam logic signed [VEL_W-1:0] FDROP_V  = VEL_W'(-FASTDROP_VEL);
    localparam logic [CNT_W-1:0]        HOLD_MAX = CNT_W'(MAX_HOLD_TICKS);
    localparam logic signed [SUM_W-1:0] HEIGHT_MAX = {2'b00, {POS_W{1'b1}}};

    motion_state_t            state_q, state_d;
    logic [POS_W-1:0]         height_q, height_d;
    logic signed [VEL_W-1:0]  vel_q, vel_d;
    logic [CNT_W-1:0]         hold_cnt_q, hold_cnt_d;
    logic                     hold_en_q, hold_en_d;
    logic                     jump_q, jump_d;
    logic                     land_q, land_d;

    logic                     held_grav;
    logic signed [VEL_W-1:0]  sub_amt;
    logic signed [VEL_W-1:0]  vel_dec;
    logic signed [SUM_W-1:0]  pos_sum;

    // Held gravity applies only while still rising on a jump whose button was never released.
    assign held_grav = (state_q == ST_RISING) && hold_en_q && button_up
                       && (hold_cnt_q < HOLD_MAX);
    assign sub_amt   = held_grav ? HOLD_V : GRAV_V;

    sat_sub #(.W(VEL_W)) u_sat_sub (
        .a_i    (vel_q),
        .b_i    (sub_amt),
        .diff_o (vel_dec)
    );

    // Position always advances with the velocity held before this cycle's update.
    assign pos_sum = $signed({2'b00, height_q}) + SUM_W'(vel_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_GROUNDED;
            height_q   <= '0;
            vel_q      <= '0;
            hold_cnt_q <= '0;
            hold_en_q  <= 1'b0;
            jump_q     <= 1'b0;
            land_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            height_q   <= height_d;
            vel_q      <= vel_d;
            hold_cnt_q <= hold_cnt_d;
            hold_en_q  <= hold_en_d;
            jump_q     <= jump_d;
            land_q     <= land_d;
        end
    end

    // NOTE: every signal gets a default before any branch so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        height_d   = height_q;
        vel_d      = vel_q;
        hold_cnt_d = hold_cnt_q;
        hold_en_d  = hold_en_q;
        jump_d     = 1'b0;
        land_d     = 1'b0;

        if (!freeze) begin
            if (game_tick[0]) begin
                unique case (state_q)
                    ST_GROUNDED: begin
                        if (button_down) begin
                            state_d = ST_DUCK;
                        end else if (button_up) begin
                            state_d    = ST_RISING;
                            vel_d      = JUMP_V;
                            hold_cnt_d = '0;
                            hold_en_d  = 1'b1;
                            jump_d     = 1'b1;
                        end
                    end
                    ST_DUCK: begin
                        if (!button_down) state_d = ST_GROUNDED;
                    end
                    ST_RISING: begin
                        if (button_down) begin
                            state_d = ST_FASTDROP;
                            vel_d   = FDROP_V;
                        end else begin
                            vel_d = vel_dec;
                            if (held_grav) hold_cnt_d = hold_cnt_q + CNT_W'(1);
                            if (!button_up) hold_en_d = 1'b0;
                            if (vel_dec[VEL_W-1] || vel_dec == '0) state_d = ST_FALLING;
                        end
                    end
                    ST_FALLING: begin
                        if (button_down) begin
                            state_d = ST_FASTDROP;
                            vel_d   = FDROP_V;
                        end else begin
                            vel_d = vel_dec;
                        end
                    end
                    default: ;
                endcase
            end

            // Touchdown and ceiling outcomes override whatever the velocity update chose.
            if (game_tick[1]) begin
                if (!is_airborne(state_q)) begin
                    height_d = '0;
                end else if (pos_sum[SUM_W-1] || pos_sum == '0) begin
                    height_d = '0;
                    vel_d    = '0;
                    land_d   = 1'b1;
                    state_d  = button_down ? ST_DUCK : ST_GROUNDED;
                end else if (pos_sum > HEIGHT_MAX) begin
                    height_d = {POS_W{1'b1}};
                    vel_d    = '0;
                    state_d  = ST_FALLING;
                end else begin
                    height_d = pos_sum[POS_W-1:0];
                end
            end
        end
    end

    always_comb begin
        height       = height_q;
        velocity     = vel_q;
        airborne     = is_airborne(state_q);
        ducking      = (state_q == ST_DUCK);
        jump_pulse   = jump_q & ~freeze;
        landed_pulse = land_q & ~freeze;
    end

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed scenarios with literal expectations
// plus a randomized run compared against a behavioural jump model.
module tb_player_motion;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        game_tick;
    logic              freeze;
    logic              button_up;
    logic              button_down;
    logic [7:0]        height;
    logic signed [7:0] velocity;
    logic              airborne;
    logic              ducking;
    logic              jump_pulse;
    logic              landed_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    player_motion dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .game_tick    (game_tick),
        .freeze       (freeze),
        .button_up    (button_up),
        .button_down  (button_down),
        .height       (height),
        .velocity     (velocity),
        .airborne     (airborne),
        .ducking      (ducking),
        .jump_pulse   (jump_pulse),
        .landed_pulse (landed_pulse)
    );

    // Behavioural model: plain integers, motion described as the player would see it.
    typedef enum {M_GROUND, M_DUCK, M_UP, M_DOWN, M_DROP} mmode_t;
    mmode_t m_mode;
    int     m_h, m_v, m_cnt;
    bit     m_en, m_jp, m_lp;

    function automatic int floor_v(input int x);
        return (x < -128) ? -128 : x;
    endfunction

    task automatic model_reset;
        m_mode = M_GROUND; m_h = 0; m_v = 0; m_cnt = 0; m_en = 0; m_jp = 0; m_lp = 0;
    endtask

    task automatic model_step(input logic [1:0] t, input logic u, input logic d, input logic f);
        int     old_h, old_v, nh;
        mmode_t old_mode;
        m_jp = 0; m_lp = 0;
        if (f) return;
        old_h = m_h; old_v = m_v; old_mode = m_mode;
        if (t[0]) begin
            case (old_mode)
                M_GROUND: if (d) m_mode = M_DUCK;
                          else if (u) begin
                              m_v = 12; m_cnt = 0; m_en = 1; m_mode = M_UP; m_jp = 1;
                          end
                M_DUCK:   if (!d) m_mode = M_GROUND;
                M_UP: begin
                    if (d) begin m_v = -8; m_mode = M_DROP; end
                    else begin
                        if (m_en && u && m_cnt < 4) begin m_v = floor_v(m_v - 1); m_cnt++; end
                        else m_v = floor_v(m_v - 2);
                        if (!u) m_en = 0;
                        if (m_v <= 0) m_mode = M_DOWN;
                    end
                end
                M_DOWN: if (d) begin m_v = -8; m_mode = M_DROP; end
                        else m_v = floor_v(m_v - 2);
                default: ;
            endcase
        end
        if (t[1] && old_mode inside {M_UP, M_DOWN, M_DROP}) begin
            nh = old_h + old_v;
            if (nh <= 0) begin
                m_h = 0; m_v = 0; m_lp = 1; m_mode = d ? M_DUCK : M_GROUND;
            end else if (nh > 255) begin
                m_h = 255; m_v = 0; m_mode = M_DOWN;
            end else m_h = nh;
        end
    endtask

    task automatic cycle(input logic [1:0] t, input logic u, input logic d, input logic f);
        @(negedge clk);
        game_tick = t; button_up = u; button_down = d; freeze = f;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset_n = 1'b0; game_tick = 2'b00; button_up = 0; button_down = 0; freeze = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic fall_to_ground(input string tag);
        for (int i = 0; i < 400 && airborne; i++) cycle(2'b11, 0, 0, 0);
        n_checks++;
        if (airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_land_timeout: airborne=%b required 0", tag, airborne);
        end
        cycle(2'b01, 0, 0, 0);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset_n = 1'b0; game_tick = 2'b11; button_up = 1; button_down = 0; freeze = 0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({height, velocity, airborne, ducking, jump_pulse, landed_pulse} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: h=%0d v=%0d air=%b duck=%b jp=%b lp=%b required all 0",
                     height, velocity, airborne, ducking, jump_pulse, landed_pulse);
        end
        @(negedge clk);
        reset_n = 1'b1; game_tick = 2'b00; button_up = 0;
        cycle(2'b00, 0, 0, 0);
        n_checks++;
        if ({height, velocity, airborne, ducking} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_idle: h=%0d v=%0d air=%b duck=%b required 0", height, velocity,
                     airborne, ducking);
        end
    endtask

    task automatic test_tap_jump;
        int exp_h [13] = '{12, 22, 30, 36, 40, 42, 42, 40, 36, 30, 22, 12, 0};
        cycle(2'b11, 1, 0, 0);
        n_checks++;
        if (jump_pulse !== 1'b1 || velocity !== 8'sd12 || height !== 8'd0 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL tap_launch: jp=%b v=%0d h=%0d air=%b required 1/12/0/1", jump_pulse,
                     velocity, height, airborne);
        end
        for (int i = 0; i < 13; i++) begin
            cycle(2'b11, 0, 0, 0);
            n_checks++;
            if (height !== 8'(exp_h[i]) || landed_pulse !== (i == 12) || jump_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL tap_step%0d: h=%0d lp=%b jp=%b required h=%0d lp=%b jp=0", i, height,
                         landed_pulse, jump_pulse, exp_h[i], (i == 12));
            end
        end
        cycle(2'b00, 0, 0, 0);
        n_checks++;
        if (airborne !== 1'b0 || ducking !== 1'b0 || landed_pulse !== 1'b0 || velocity !== 8'sd0) begin
            n_fail++;
            $display("FAIL tap_grounded: air=%b duck=%b lp=%b v=%0d required 0/0/0/0", airborne,
                     ducking, landed_pulse, velocity);
        end
    endtask

    task automatic test_hold_jump;
        int exp_v [8] = '{11, 10, 9, 8, 6, 4, 2, 0};
        int exp_h [8] = '{12, 23, 33, 42, 50, 56, 60, 62};
        cycle(2'b11, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(2'b11, 1, 0, 0);
            n_checks++;
            if (velocity !== 8'(exp_v[i]) || height !== 8'(exp_h[i])) begin
                n_fail++;
                $display("FAIL hold_step%0d: v=%0d h=%0d required v=%0d h=%0d", i, velocity, height,
                         exp_v[i], exp_h[i]);
            end
        end
        cycle(2'b11, 1, 0, 0);
        n_checks++;
        if (velocity !== -8'sd2 || height !== 8'd62) begin
            n_fail++;
            $display("FAIL hold_falling: v=%0d h=%0d required v=-2 h=62", velocity, height);
        end
        fall_to_ground("hold");
    endtask

    task automatic test_fast_drop;
        int exp_h [6] = '{34, 26, 18, 10, 2, 0};
        cycle(2'b11, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(2'b11, 0, 0, 0);
        n_checks++;
        if (height !== 8'd42 || velocity !== 8'sd0) begin
            n_fail++;
            $display("FAIL drop_apex: h=%0d v=%0d required h=42 v=0", height, velocity);
        end
        cycle(2'b11, 0, 1, 0);
        n_checks++;
        if (height !== 8'd42 || velocity !== -8'sd8) begin
            n_fail++;
            $display("FAIL drop_start: h=%0d v=%0d required h=42 v=-8", height, velocity);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(2'b11, 0, 1, 0);
            n_checks++;
            if (height !== 8'(exp_h[i]) || landed_pulse !== (i == 5)
                || velocity !== ((i == 5) ? 8'sd0 : -8'sd8)) begin
                n_fail++;
                $display("FAIL drop_step%0d: h=%0d v=%0d lp=%b required h=%0d lp=%b", i, height,
                         velocity, landed_pulse, exp_h[i], (i == 5));
            end
        end
        n_checks++;
        if (ducking !== 1'b1 || airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_duck: duck=%b air=%b required 1/0", ducking, airborne);
        end
        cycle(2'b11, 0, 1, 0);
        n_checks++;
        if (ducking !== 1'b1 || landed_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_duck_hold: duck=%b lp=%b required 1/0", ducking, landed_pulse);
        end
        cycle(2'b01, 0, 0, 0);
        n_checks++;
        if (ducking !== 1'b0 || airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_release: duck=%b air=%b required 0/0", ducking, airborne);
        end
    endtask

    task automatic test_up_down_ground;
        for (int i = 0; i < 2; i++) begin
            cycle(2'b11, 1, 1, 0);
            n_checks++;
            if (ducking !== 1'b1 || jump_pulse !== 1'b0 || airborne !== 1'b0) begin
                n_fail++;
                $display("FAIL updown_duck%0d: duck=%b jp=%b air=%b required 1/0/0", i, ducking,
                         jump_pulse, airborne);
            end
        end
        cycle(2'b01, 1, 0, 0);
        n_checks++;
        if (ducking !== 1'b0 || jump_pulse !== 1'b0 || airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL updown_release: duck=%b jp=%b air=%b required 0/0/0", ducking,
                     jump_pulse, airborne);
        end
        cycle(2'b00, 0, 0, 0);
    endtask

    task automatic test_freeze;
        cycle(2'b11, 1, 0, 0);
        @(negedge clk);
        freeze = 1'b1; game_tick = 2'b11; button_up = 0;
        #1;
        n_checks++;
        if (jump_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_gates_pulse: jp=%b required 0", jump_pulse);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (height !== 8'd0 || velocity !== 8'sd12) begin
            n_fail++;
            $display("FAIL freeze_launch_hold: h=%0d v=%0d required h=0 v=12", height, velocity);
        end
        cycle(2'b11, 0, 0, 0);
        cycle(2'b11, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(2'b11, 1'($urandom), 1'($urandom), 1);
            n_checks++;
            if (height !== 8'd22 || velocity !== 8'sd8 || jump_pulse !== 1'b0
                || landed_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze_hold%0d: h=%0d v=%0d jp=%b lp=%b required 22/8/0/0", i,
                         height, velocity, jump_pulse, landed_pulse);
            end
        end
        cycle(2'b11, 0, 0, 0);
        n_checks++;
        if (height !== 8'd30 || velocity !== 8'sd6) begin
            n_fail++;
            $display("FAIL freeze_resume: h=%0d v=%0d required h=30 v=6", height, velocity);
        end
        fall_to_ground("freeze");
    endtask

    task automatic test_ceiling;
        cycle(2'b11, 1, 0, 0);
        for (int i = 1; i <= 21; i++) begin
            cycle(2'b10, 1, 0, 0);
            n_checks++;
            if (height !== 8'(12 * i) || velocity !== 8'sd12) begin
                n_fail++;
                $display("FAIL ceil_climb%0d: h=%0d v=%0d required h=%0d v=12", i, height,
                         velocity, 12 * i);
            end
        end
        cycle(2'b10, 1, 0, 0);
        n_checks++;
        if (height !== 8'd255 || velocity !== 8'sd0 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL ceil_clamp: h=%0d v=%0d air=%b required 255/0/1", height, velocity,
                     airborne);
        end
        cycle(2'b01, 1, 0, 0);
        n_checks++;
        if (velocity !== -8'sd2) begin
            n_fail++;
            $display("FAIL ceil_falling: v=%0d required -2", velocity);
        end
        fall_to_ground("ceil");
    endtask

    task automatic test_vel_saturation;
        cycle(2'b11, 1, 0, 0);
        cycle(2'b01, 0, 0, 0);
        n_checks++;
        if (velocity !== 8'sd10 || height !== 8'd0 || airborne !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_first: v=%0d h=%0d air=%b required 10/0/1", velocity, height,
                     airborne);
        end
        for (int i = 0; i < 80; i++) cycle(2'b01, 0, 0, 0);
        n_checks++;
        if (velocity !== -8'sd128 || height !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_floor: v=%0d h=%0d required v=-128 h=0", velocity, height);
        end
        cycle(2'b10, 0, 0, 0);
        n_checks++;
        if (landed_pulse !== 1'b1 || velocity !== 8'sd0 || airborne !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_land: lp=%b v=%0d air=%b required 1/0/0", landed_pulse, velocity,
                     airborne);
        end
        cycle(2'b00, 0, 0, 0);
    endtask

    task automatic test_async_reset;
        cycle(2'b11, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(2'b11, 0, 0, 0);
        n_checks++;
        if (height !== 8'd30) begin
            n_fail++;
            $display("FAIL areset_setup: h=%0d required 30", height);
        end
        @(negedge clk);
        game_tick = 2'b00;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({height, velocity, airborne, ducking, jump_pulse, landed_pulse} !== 20'h0) begin
            n_fail++;
            $display("FAIL areset_immediate: h=%0d v=%0d air=%b duck=%b required all 0", height,
                     velocity, airborne, ducking);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cycle(2'b11, 1, 0, 0);
        n_checks++;
        if (jump_pulse !== 1'b1 || velocity !== 8'sd12 || height !== 8'd0) begin
            n_fail++;
            $display("FAIL areset_first_strobe: jp=%b v=%0d h=%0d required 1/12/0", jump_pulse,
                     velocity, height);
        end
        fall_to_ground("areset");
    endtask

    task automatic test_random;
        logic [1:0]  t;
        logic        u, d, f;
        logic [19:0] obs, exp_vec;
        apply_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            t = 2'($urandom);
            u = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 5) == 0);
            f = ($urandom_range(0, 9) == 0);
            cycle(t, u, d, f);
            model_step(t, u, d, f);
            obs     = {height, velocity, airborne, ducking, jump_pulse, landed_pulse};
            exp_vec = {8'(m_h), 8'(m_v), m_mode inside {M_UP, M_DOWN, M_DROP},
                       m_mode == M_DUCK, m_jp, m_lp};
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got h=%0d v=%0d flags=%b required h=%0d v=%0d flags=%b",
                         i, obs[19:12], $signed(obs[11:4]), obs[3:0], m_h, m_v, exp_vec[3:0]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1; game_tick = 2'b00; freeze = 0; button_up = 0; button_down = 0;
        test_reset();
        test_tap_jump();
        test_hold_jump();
        test_fast_drop();
        test_up_down_ground();
        test_freeze();
        test_ceiling();
        test_vel_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_motion.md
PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 Parameter POS_W, default 8, meaning height width in bits (unsigned, 0 = ground).
REQ-002 Parameter VEL_W, default 8, meaning signed velocity width (positive = upward).
REQ-003 Parameters JUMP_VEL 12, GRAVITY 2, HOLD_GRAVITY 1, FASTDROP_VEL 8, MAX_HOLD_TICKS 4: launch velocity, normal deceleration, deceleration while jump held, fast-drop speed magnitude, maximum held-gravity updates.
REQ-004 Ports, clock and reset first:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous active-low.
- game_tick  in  2  [0] velocity-update strobe, [1] position-update strobe.
- freeze  in  1  high holds all motion state (crash / game over).
- button_up  in  1  jump request / hold.
- button_down  in  1  duck on ground, fast drop in air.
- height  out  POS_W  current height above ground.
- velocity  out  VEL_W  current signed velocity.
- airborne  out  1  state is RISING, FALLING or FASTDROP.
- ducking  out  1  state is DUCK.
- jump_pulse  out  1  one clk high on launch.
- landed_pulse  out  1  one clk high on touchdown.

Function
REQ-005 States SHALL be GROUNDED, DUCK, RISING, FALLING, FASTDROP; all updates occur only on strobe cycles with freeze low.
REQ-006 GROUNDED, tick0: button_down -> DUCK (down wins over simultaneous up); else button_up -> velocity=JUMP_VEL, hold_cnt=0, hold_en=1, RISING, jump_pulse.
REQ-007 DUCK, tick0: button_down low -> GROUNDED; no jump from DUCK.
REQ-008 RISING, tick0: button_down -> velocity=-FASTDROP_VEL, FASTDROP; else velocity -= (hold_en && button_up && hold_cnt<MAX_HOLD_TICKS) ? HOLD_GRAVITY : GRAVITY.
REQ-009 A held-gravity update SHALL increment hold_cnt; releasing button_up in RISING clears hold_en permanently for that jump.
REQ-010 RISING SHALL go to FALLING on the tick0 whose updated velocity is <= 0.
REQ-011 FALLING, tick0: button_down -> velocity=-FASTDROP_VEL, FASTDROP; else velocity -= GRAVITY. FASTDROP holds velocity constant.
REQ-012 Velocity subtraction SHALL saturate at the signed VEL_W minimum; no wrap.
REQ-013 Tick1 in air: next = height + sign-extended velocity computed at POS_W+2 bits.
REQ-014 next <= 0 -> height=0, velocity=0, landed_pulse, state DUCK if button_down else GROUNDED.
REQ-015 next > 2^POS_W-1 -> height saturates at max, velocity=0, state FALLING.
REQ-016 Tick1 on ground SHALL leave height 0.
REQ-017 When both tick bits are high, position SHALL use the pre-update velocity and both updates commit in the same cycle.
REQ-018 jump_pulse and landed_pulse SHALL be registered, one clk wide, and low while freeze is high.

Reset
REQ-019 reset_n low SHALL immediately clear height, velocity, hold_cnt, hold_en and pulses, and set state GROUNDED, including mid-jump.
REQ-020 The first strobe after reset_n release SHALL be evaluated normally.

Structure
REQ-021 Shared package player_pkg SHALL hold the state encoding (3 bits: GROUNDED 0, DUCK 1, RISING 2, FALLING 3, FASTDROP 4) and the default physics constants.
REQ-022 One sub-module, sat_sub, SHALL implement the VEL_W signed saturating subtract.

Verification (defaults)
REQ-023 Tap up for one tick0 from GROUNDED: jump_pulse; heights 12,22,30,36,40,42,42; then descent; landed_pulse; GROUNDED.
REQ-024 Hold up throughout: velocities 11,10,9,8,6,4,2,0; peak height 62; FALLING after v=0.
REQ-025 At height 42 in FALLING, press down: velocity -8; heights 34,26,...,2, then 0; landed_pulse; DUCK while down held.
REQ-026 Up and down together on ground: DUCK, no jump_pulse; release down -> GROUNDED.
REQ-027 Assert freeze mid-rise for 10 strobes: height and velocity unchanged, no pulses; resume on release.
REQ-028 reset_n low at height 30: outputs cleared asynchronously, before the next clk edge.
